// File: rtl/serial_add_pkg.sv
// Shared encodings and parameter bounds for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/halfadd.sv
// Half-adder cell of the shared adder datapath.
module halfadd (
  input  logic a,
  input  logic b,
  output logic c,
  output logic sum
);

  assign sum = a ^ b;
  assign c   = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell (2x halfadd + OR) reused
// LSB-first over WIDTH cycles, carry kept in a flop.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_co;
  logic             w_last;

  halfadd u_ha0 (
    .a   (r_sh_a[0]),
    .b   (r_sh_b[0]),
    .c   (w_c1),
    .sum (w_s1)
  );

  halfadd u_ha1 (
    .a   (w_s1),
    .b   (r_carry),
    .c   (w_c2),
    .sum (w_s)
  );

  assign w_co   = w_c1 | w_c2;
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // new sum bit enters at the MSB; works for WIDTH=1 too
  assign w_acc_nxt = WIDTH'({w_s, r_acc} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (r_state == ST_RUN):  busy = 1'b1;
      (r_state == ST_DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sh_a  <= op_a;
            r_sh_b  <= op_b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_nxt;
          r_sh_a  <= r_sh_a >> 1;
          r_sh_b  <= r_sh_b >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_cout   <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8 main, WIDTH=1 side).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  logic start1, a1, b1, c1;
  logic busy1, done1, res1, cout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .op_a   (a1),
    .op_b   (b1),
    .cin    (c1),
    .busy   (busy1),
    .done   (done1),
    .result (res1),
    .cout   (cout1)
  );

  typedef struct {
    logic [W:0] sum;
    int         dcyc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc     = 0;
  bit         active  = 0;
  int         cur_k   = 0;
  int         free_at = 0;
  logic [W:0] cur_sum = '0;
  logic [W:0] hold    = '0;
  logic       exp_busy;
  logic       exp_done;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: an op accepted at edge k ends with its sum at edge k+W
  initial forever begin
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (active && cyc == cur_k + W) hold = cur_sum;
      if (active && cyc == cur_k + W + 1) active = 0;
      if (start === 1'b1 && cyc >= free_at) begin
        cur_k   = cyc;
        active  = 1;
        cur_sum = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
        free_at = cyc + W + 2;
        q.push_back('{cur_sum, cyc + W + 1});
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge rst_n);
    q.delete();
    active  = 0;
    hold    = '0;
    free_at = 0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      exp_busy = active && cyc >= cur_k + 1 && cyc <= cur_k + W;
      exp_done = active && cyc == cur_k + W + 1;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("hold", 32'({cout, result}), 32'(hold));
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 want no pending op");
        end else begin
          e = q.pop_front();
          chk("sum", 32'({cout, result}), 32'(e.sum));
          chk("latency", 32'(cyc), 32'(e.dcyc));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    cin   = 1'($urandom);
    repeat (W + 1) @(negedge clk);
  endtask

  initial begin
    int n;
    int s;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    c1     = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_busy1", 32'(busy1), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    issue(8'h00, 8'h00, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hA5, 8'h5A, 1'b1);
    issue(8'h3C, 8'h42, 1'b0);

    // second start during RUN must be dropped
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'h11;
    op_b  = 8'h22;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'h77;
    op_b  = 8'h66;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);

    @(negedge clk);
    start = 1'b1;
    op_a  = 8'h10;
    op_b  = 8'h20;
    cin   = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // abort in RUN cycle 4
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'hC3;
    op_b  = 8'h5F;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_cout", 32'(cout), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(8'h12, 8'h34, 1'b1);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b1;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      cin   = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      repeat ($urandom_range(W - 2, W + 4)) @(negedge clk);
    end

    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1;
      a1 = i[0];
      b1 = i[1];
      c1 = i[2];
      s  = int'(i[0]) + int'(i[1]) + int'(i[2]);
      @(negedge clk);
      start1 = 1'b0;
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      chk("w1_busy", 32'(busy1), 1);
      chk("w1_done_early", 32'(done1), 0);
      @(negedge clk);
      chk("w1_done", 32'(done1), 1);
      chk("w1_busy_off", 32'(busy1), 0);
      chk("w1_sum", 32'({cout1, res1}), 32'(s));
      @(negedge clk);
      chk("w1_idle", 32'({busy1, done1}), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that time-shares a single full-adder cell, built from two halfadd instances plus an OR, across WIDTH clock cycles.
- Accepts operands on a start pulse, then sequences LSB-to-MSB through the cell while holding the carry in a flop.
- Reports the result with a done pulse.
- Sits beside the halfadd datapath as its sequencer. It is the area-minimal adder option for slow control paths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A; captured on accepted start
op_b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/cout valid
result  output  WIDTH  sum; held from done until next accepted start
cout  output  1  final carry-out; same validity as result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async assert, sync-safe deassert): state=IDLE; busy=0, done=0, result=0, cout=0; internal shift regs, carry flop and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start=1:
  - load sh_a<=op_a, sh_b<=op_b, carry<=cin, cnt<=0, acc<=0.
  - result/cout keep their previous values.
- RUN, each cycle:
  - cell inputs are sh_a[0], sh_b[0], carry.
  - s = (sh_a[0]^sh_b[0])^carry, via two halfadd instances.
  - co = c1|c2.
  - acc <= {s, acc[WIDTH-1:1]}; sh_a/sh_b shift right with zero fill; carry<=co; cnt<=cnt+1.
- RUN -> DONE on the edge where cnt==WIDTH-1 (the last bit is processed that cycle). On that edge:
  - result<={s, acc[WIDTH-1:1]}.
  - cout<=co.
- DONE: done=1 for exactly one cycle; unconditional -> IDLE.
- Latency: start sampled at edge k gives busy=1 in cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE: ignored, not queued. op_a/op_b/cin may change freely after acceptance.
- start held high continuously: a new operation is accepted on the first IDLE edge after done.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1); unsigned; no overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.
- cnt width: $clog2(WIDTH+1) bits; it never wraps within an operation.
- Reset mid-RUN: operation aborted; outputs return to reset values immediately (asynchronously); no done pulse.
- busy and done are mutually exclusive; both are low in IDLE.

Decomposition:
- Package serial_add_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - WIDTH legality bounds.
- Sub-module: reuse the existing halfadd (ports a, b, c, sum) twice to form the full-adder cell.
  - The cell may be wrapped as full_add_cell (2× halfadd + OR) if preferred.
  - No other sub-modules.

Test Plan:
- WIDTH=8, start with op_a=0x00, op_b=0x00, cin=0 -> busy 8 cycles; done at k+9; result=0x00, cout=0.
- WIDTH=8, op_a=0xFF, op_b=0x01, cin=0 -> result=0x00, cout=1. Then op_a=0xA5, op_b=0x5A, cin=1 -> result=0x00, cout=1. Then op_a=0x3C, op_b=0x42, cin=0 -> result=0x7E, cout=0.
- Start pulsed again in RUN cycle 3 with different operands -> ignored; result matches the first operands; exactly one done pulse.
- start held high continuously with fixed op_a=0x10, op_b=0x20 -> done every 10 cycles; result=0x30 each time; busy low only in DONE and IDLE cycles.
- rst_n asserted in RUN cycle 4 -> busy, done, result, cout go to 0 immediately. No done pulse follows. Next start after reset release completes normally.
- WIDTH=1, op_a=1, op_b=1, cin=1 -> busy 1 cycle; done at k+2; result=1, cout=1.
